// File: rtl/reg_file_multi_port.sv
// Multi-port register file with two write ports, same-cycle write bypass, a
// per-register busy scoreboard and a post-reset clear sweep of the array.
module reg_file_multi_port #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 3,
  parameter int unsigned SYNC_READ  = 0,
  localparam int unsigned SEL_W     = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*SEL_W-1:0]      rd_sel,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr0_en,
  input  logic [SEL_W-1:0]             wr0_sel,
  input  logic [DATA_WIDTH-1:0]        wr0_data,
  input  logic                         wr1_en,
  input  logic [SEL_W-1:0]             wr1_sel,
  input  logic [DATA_WIDTH-1:0]        wr1_data,
  input  logic                         busy_set_en,
  input  logic [SEL_W-1:0]             busy_set_sel,
  output logic                         init_done
);

  localparam int unsigned LAST_IDX = NUM_REGS - 1;

  // Elaboration-time guard on the legal parameter space.
  if (NUM_REGS < 4 || NUM_REGS > 64 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("NUM_REGS must be a power of two in 4..64");
  end
  if (NUM_RD < 1 || NUM_RD > 6) begin : g_bad_num_rd
    $error("NUM_RD must be in 1..6");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sweep_q, sweep_d;
  logic                    init_done_q, init_done_d;
  logic [NUM_REGS-1:0]     busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   mem_d [NUM_REGS];

  logic                    run_c;
  logic                    wr0_hit_c;
  logic                    wr1_hit_c;
  logic                    busy_set_hit_c;
  logic [SEL_W-1:0]        rd_idx_c  [NUM_RD];
  logic [DATA_WIDTH-1:0]   rd_word_c [NUM_RD];
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_d;

  // Writes and busy marks only take effect once the sweep has finished; r0 is hardwired.
  assign run_c          = (state_q == ST_RUN);
  assign wr0_hit_c      = run_c && wr0_en && (wr0_sel != '0);
  assign wr1_hit_c      = run_c && wr1_en && (wr1_sel != '0);
  assign busy_set_hit_c = run_c && busy_set_en && (busy_set_sel != '0);

  // Sweep sequencing: one register cleared per cycle, then RUN until reset.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + SEL_W'(1);
        if (sweep_q == SEL_W'(LAST_IDX)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          sweep_d     = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_INIT;
        sweep_d     = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  assign init_done = init_done_q;

  // Array update: the sweep zeroes entries; in RUN wr1 is applied last so it wins.
  always_comb begin
    mem_d = mem_q;
    if (!run_c) begin
      mem_d[sweep_q] = '0;
    end else begin
      if (wr0_hit_c) mem_d[wr0_sel] = wr0_data;
      if (wr1_hit_c) mem_d[wr1_sel] = wr1_data;
    end
  end

  // Contents are deliberately not reset; the sweep clears them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Scoreboard: writes retire a producer, a same-cycle new producer takes precedence.
  always_comb begin
    busy_d = busy_q;
    if (wr0_hit_c)      busy_d[wr0_sel]      = 1'b0;
    if (wr1_hit_c)      busy_d[wr1_sel]      = 1'b0;
    if (busy_set_hit_c) busy_d[busy_set_sel] = 1'b1;
    busy_d[0] = 1'b0;
  end

  for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_lane
    assign rd_idx_c[g] = rd_sel[g*SEL_W +: SEL_W];
    assign rd_data_d[g*DATA_WIDTH +: DATA_WIDTH] = rd_word_c[g];
  end

  // Read lanes with bypass; wr1 is checked last so it has priority over wr0.
  always_comb begin
    rd_word_c = '{default: '0};
    rd_busy   = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      rd_word_c[i] = mem_q[rd_idx_c[i]];
      if (wr0_hit_c && (wr0_sel == rd_idx_c[i])) rd_word_c[i] = wr0_data;
      if (wr1_hit_c && (wr1_sel == rd_idx_c[i])) rd_word_c[i] = wr1_data;
      if (!run_c || (rd_idx_c[i] == '0))          rd_word_c[i] = '0;
      rd_busy[i] = busy_q[rd_idx_c[i]]
                   & ~((wr0_hit_c && (wr0_sel == rd_idx_c[i]))
                     || (wr1_hit_c && (wr1_sel == rd_idx_c[i])));
    end
  end

  if (SYNC_READ != 0) begin : g_sync_rd
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
    end
    assign rd_data = rd_data_q;
  end else begin : g_comb_rd
    assign rd_data = rd_data_d;
  end

endmodule
